// File: rtl/probador_pkg.sv
// probador_pkg: shared states, expected gate truth table and fail_mask bit positions for probador_compuertas
package probador_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  localparam int BIT_NOT  = 5;
  localparam int BIT_AND  = 4;
  localparam int BIT_OR   = 3;
  localparam int BIT_XOR  = 2;
  localparam int BIT_XNOR = 1;
  localparam int BIT_NAND = 0;
  localparam logic [5:0] EXP_TBL [4] = '{6'b100011, 6'b101101, 6'b001101, 6'b011010};
endpackage

// File: rtl/probador_compuertas.sv
// probador_compuertas: drives A/B through 00,01,10,11 on start, checks Snot..Snand against the truth table; reports busy, done, pass, fail_mask, err_cnt
module probador_compuertas
  import probador_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Snot,
  input  logic       Sand,
  input  logic       Sor,
  input  logic       Sxor,
  input  logic       Sxnor,
  input  logic       Snand,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
  output logic [2:0] err_cnt
);
  localparam logic [7:0] LAST = 8'(SETTLE_CYC - 1);
  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] mask_q, mask_d, got, mis;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  always_comb begin
    got           = '0;
    got[BIT_NOT]  = Snot;
    got[BIT_AND]  = Sand;
    got[BIT_OR]   = Sor;
    got[BIT_XOR]  = Sxor;
    got[BIT_XNOR] = Sxnor;
    got[BIT_NAND] = Snand;
    mis           = got ^ EXP_TBL[vec_q];
    state_d       = state_q;
    vec_d         = vec_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q;
    err_d         = err_q;
    pass_d        = pass_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        vec_d   = '0;
        cnt_d   = '0;
        mask_d  = '0;
        err_d   = '0;
        pass_d  = 1'b0;
      end
      SETTLE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == LAST) ? CHECK : SETTLE;
      end
      CHECK: begin
        mask_d  = mask_q | mis;
        err_d   = err_q + {2'b00, |mis};
        cnt_d   = '0;
        state_d = (vec_q == 2'd3) ? DONE : SETTLE;
        vec_d   = (vec_q == 2'd3) ? vec_q : vec_q + 2'd1;
        pass_d  = (vec_q == 2'd3) ? (mask_d == '0) : pass_q;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end
  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign A         = busy & vec_q[1];
  assign B         = busy & vec_q[0];
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign err_cnt   = err_q;
endmodule

// File: tb/tb_probador_compuertas.sv
// tb_probador_compuertas: table-driven and randomized self-check of probador_compuertas against a truth-table reference model
module tb_probador_compuertas;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic [3:0][5:0] flt0 = '0, flt1 = '0;
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [5:0] g0, g1, mask0, mask1;
  logic [2:0] err0, err1;
  logic [13:0] obs;
  int sel = 0;
  int passed = 0, total = 0;
  function automatic logic [5:0] ideal(input logic a, input logic b);
    return {~a, a & b, a | b, a ^ b, ~(a ^ b), ~(a & b)};
  endfunction
  assign g0 = ideal(a0, b0) ^ flt0[{a0, b0}];
  assign g1 = ideal(a1, b1) ^ flt1[{a1, b1}];
  always_comb obs = (sel == 1) ? {a1, b1, busy1, done1, pass1, mask1, err1}
                               : {a0, b0, busy0, done0, pass0, mask0, err0};
  probador_compuertas #(.SETTLE_CYC(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0),
    .Snot(g0[5]), .Sand(g0[4]), .Sor(g0[3]), .Sxor(g0[2]), .Sxnor(g0[1]), .Snand(g0[0]),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0), .err_cnt(err0));
  probador_compuertas #(.SETTLE_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
    .Snot(g1[5]), .Sand(g1[4]), .Sor(g1[3]), .Sxor(g1[2]), .Sxnor(g1[1]), .Snand(g1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1), .err_cnt(err1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic model(input logic [3:0][5:0] f, output logic [5:0] m, output logic [2:0] e, output logic p);
    logic [5:0] truth [4];
    logic [5:0] d;
    truth = '{6'b100011, 6'b101101, 6'b001101, 6'b011010};
    m = '0;
    e = '0;
    for (int v = 0; v < 4; v++) begin
      d = (ideal(v[1], v[0]) ^ f[v]) ^ truth[v];
      m |= d;
      if (d != 0) e++;
    end
    p = (m == 0);
  endtask
  task automatic set_start(input int s, input logic v);
    if (s == 1) start1 = v;
    else start0 = v;
  endtask
  task automatic run(input int s, input int settle, input int again, input string tag,
                     output logic [5:0] m, output logic [2:0] e, output logic p);
    int done_at, ndone, hold, last;
    logic seq_ok, exp_busy;
    logic [1:0] exp_ab;
    done_at = 0; ndone = 0; seq_ok = 1'b1;
    hold = settle + 1;
    last = 1 + 4 * hold;
    m = '0; e = '0; p = 1'b0;
    sel = s;
    @(negedge clk);
    set_start(s, 1'b1);
    for (int k = 1; k <= last + 4; k++) begin
      @(negedge clk);
      set_start(s, k == again);
      exp_busy = (k < last);
      exp_ab = exp_busy ? 2'((k - 1) / hold) : 2'b00;
      if (obs[11] !== exp_busy || obs[13:12] !== exp_ab) seq_ok = 1'b0;
      if (obs[10]) begin
        ndone++;
        done_at = k;
        m = obs[8:3];
        e = obs[2:0];
        p = obs[9];
      end
    end
    chk({tag, " done_cycle"}, done_at, last);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " ab_busy_seq"}, {31'b0, seq_ok}, 1);
    chk({tag, " held_results"}, {22'b0, obs[9:0]}, {22'b0, p, m, e});
  endtask
  typedef struct {
    string           name;
    logic [3:0][5:0] f;
    logic [5:0]      m;
    logic [2:0]      e;
    logic            p;
    int              again;
  } vec_t;
  vec_t tbl [5];
  initial begin
    logic [5:0] m, em;
    logic [2:0] e, ee;
    logic p, ep;
    logic [3:0][5:0] f;
    int nd;
    tbl[0] = '{"good",        '0,                                       6'b000000, 3'd0, 1'b1, 0};
    tbl[1] = '{"and_stuck0",  {6'b010000, 6'b0, 6'b0, 6'b0},            6'b010000, 3'd1, 1'b0, 0};
    tbl[2] = '{"not_inv",     {4{6'b100000}},                           6'b100000, 3'd4, 1'b0, 0};
    tbl[3] = '{"restart_mid", '0,                                       6'b000000, 3'd0, 1'b1, 5};
    tbl[4] = '{"start_done",  {6'b0, 6'b000001, 6'b000001, 6'b0},       6'b000001, 3'd2, 1'b0, 13};
    repeat (3) @(negedge clk);
    chk("reset_u0", {18'b0, a0, b0, busy0, done0, pass0, mask0, err0}, 0);
    chk("reset_u1", {18'b0, a1, b1, busy1, done1, pass1, mask1, err1}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      flt0 = tbl[i].f;
      run(0, 2, tbl[i].again, tbl[i].name, m, e, p);
      chk({tbl[i].name, " fail_mask"}, {26'b0, m}, {26'b0, tbl[i].m});
      chk({tbl[i].name, " err_cnt"}, {29'b0, e}, {29'b0, tbl[i].e});
      chk({tbl[i].name, " pass"}, {31'b0, p}, {31'b0, tbl[i].p});
    end
    flt1 = '0;
    run(1, 1, 0, "settle1", m, e, p);
    chk("settle1 pass", {31'b0, p}, 1);
    flt0 = {4{6'b100000}};
    sel = 0;
    @(negedge clk);
    start0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset", {18'b0, a0, b0, busy0, done0, pass0, mask0, err0}, 0);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) nd++;
    end
    chk("midrun_reset no_done", nd, 0);
    flt0 = '0;
    run(0, 2, 0, "after_reset", m, e, p);
    chk("after_reset pass", {31'b0, p}, 1);
    for (int i = 0; i < 16; i++) begin
      for (int v = 0; v < 4; v++) f[v] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      model(f, em, ee, ep);
      if (i % 2 == 1) flt1 = f;
      else flt0 = f;
      run(i % 2, (i % 2 == 1) ? 1 : 2, 0, $sformatf("rand%0d", i), m, e, p);
      chk($sformatf("rand%0d result", i), {22'b0, p, m, e}, {22'b0, ep, em, ee});
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/probador_compuertas.md
# probador_compuertas

Sequential self-check driver for the two-input gate block (NOT/AND/OR/XOR/XNOR/NAND). On a start pulse it drives the A/B inputs through all four combinations and waits a programmable settle time per vector. It then samples the six gate outputs, compares them against the truth table, and reports a per-gate failure mask, a mismatch count and a pass flag. It sits beside the gate block on a board or bench top level, driving its inputs and consuming its outputs.

## Interface
- SETTLE_CYC, 2, cycles each vector is held before sampling; legal range 1..255
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin a test run; sampled only in IDLE
- A  output  1  gate input A driven to the gate block
- B  output  1  gate input B driven to the gate block
- Snot, Sand, Sor, Sxor, Sxnor, Snand  input  1 each  gate block outputs under test
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  single-cycle pulse at end of run
- pass  output  1  1 when last completed run had zero mismatches; held until next accepted start
- fail_mask  output  6  sticky per-gate mismatch bits: [5]=not [4]=and [3]=or [2]=xor [1]=xnor [0]=nand
- err_cnt  output  3  number of vectors (0..4) with at least one mismatching gate

## Operation
- Vector register vec[1:0]; A=vec[1], B=vec[0]; order 00, 01, 10, 11.
- Expected {not,and,or,xor,xnor,nand}: 00→100011, 01→101101, 10→001101, 11→011010.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: A=B=0, busy=0. start=1 → vec←0, settle counter←0, fail_mask←0, err_cnt←0, pass←0, go SETTLE.
- SETTLE: busy=1; counter increments each cycle; when counter==SETTLE_CYC-1 → CHECK.
- CHECK: busy=1; sample the six inputs; mismatch = sampled XOR expected[vec]; fail_mask |= mismatch; if mismatch≠0, err_cnt+1. If vec==3 → DONE, else vec+1, counter←0, SETTLE.
- DONE: done=1, busy=0, pass←(final fail_mask==0); next cycle IDLE.
- start outside IDLE is ignored; it is not queued.
- err_cnt saturates naturally at 4 (never exceeds); it does not wrap.
- fail_mask, err_cnt and pass hold their values in IDLE until the next accepted start.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE; A=0, B=0, busy=0, done=0, pass=0, fail_mask=0, err_cnt=0, vec=0, counter=0.
- Reset mid-run aborts immediately and applies the same values. No done pulse is produced.
- start sampled at edge 0 → busy=1 and A/B=vec 00 from cycle 1.
- Each vector occupies SETTLE_CYC+1 cycles: SETTLE_CYC in SETTLE, then 1 in CHECK.
- A/B change on the edge leaving CHECK. The six inputs are sampled at the end of the CHECK cycle, so a vector is held at least SETTLE_CYC+1 cycles before sampling.
- done asserted in cycle 1+4·(SETTLE_CYC+1); with the default this is cycle 13.
- pass, fail_mask and err_cnt are valid in the done cycle and stay stable afterwards.
- start high in the DONE cycle is ignored. A new run needs start in IDLE, at the earliest the cycle after done.

## Structure
- Shared package probador_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - 4-entry × 6-bit expected-value constant table indexed by vec
  - fail_mask bit-position constants
- Single module; no sub-module is needed. The settle counter and comparator are small enough to stay inline.
- Settle counter width is 8 bits, sized for SETTLE_CYC≤255.

## Test plan
- Correct gate model attached, SETTLE_CYC=2, start at cycle 0 → A/B sequence 00,01,10,11 each held 3 cycles; done at cycle 13; pass=1, fail_mask=000000, err_cnt=0.
- Sand stuck at 0 → only vector 11 mismatches; fail_mask=010000, err_cnt=1, pass=0.
- Snot inverted → every vector mismatches; fail_mask=100000, err_cnt=4, pass=0.
- start pulsed again at cycle 5 mid-run → ignored; single done at cycle 13, results identical to a single run.
- rst_n=0 at cycle 7 mid-run → next cycle A=B=0, busy=0, pass=0, fail_mask=0, err_cnt=0; no done pulse; a fresh start afterwards completes normally.
- SETTLE_CYC=1, correct model → each vector held 2 cycles; done at cycle 9; pass=1.
